// File: rtl/modexp_arbiter.sv
// Round-robin front end sharing one modular-exponentiation engine between
// two requesters. Grants, captures operands, launches the engine, returns the
// result with a per-requester done pulse. A zero modulus is rejected without
// starting the engine.
module modexp_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] m0,
  input  logic [WIDTH-1:0] e0,
  input  logic [WIDTH-1:0] n0,
  input  logic [WIDTH-1:0] m1,
  input  logic [WIDTH-1:0] e1,
  input  logic [WIDTH-1:0] n1,
  output logic             ack0,
  output logic             ack1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy,
  output logic             exp_go,
  output logic [WIDTH-1:0] exp_m,
  output logic [WIDTH-1:0] exp_e,
  output logic [WIDTH-1:0] exp_n,
  input  logic [WIDTH-1:0] exp_result,
  input  logic             exp_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             owner;
  logic             grant;
  logic             grant_id;
  logic [WIDTH-1:0] sel_m, sel_e, sel_n;
  logic [WIDTH-1:0] op_m, op_e, op_n;

  // Arbitration: single request wins outright, a tie goes to the requester
  // that was not granted last time.
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (state == IDLE) begin
      if (req0 && req1) begin
        grant    = 1'b1;
        grant_id = ~last_grant;
      end else if (req0) begin
        grant    = 1'b1;
        grant_id = 1'b0;
      end else if (req1) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end
    sel_m = grant_id ? m1 : m0;
    sel_e = grant_id ? e1 : e0;
    sel_n = grant_id ? n1 : n0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic plus the state-decoded outputs busy and exp_go.
  always_comb begin
    state_nxt = state;
    exp_go    = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant) state_nxt = (sel_n == '0) ? RESP : ISSUE;
      end
      ISSUE: begin
        exp_go    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (exp_done) state_nxt = RESP;
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, ownership, result/err, and the registered
  // ack/done pulses (ack follows the grant edge, done follows RESP).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_m       <= '0;
      op_e       <= '0;
      op_n       <= '0;
      result     <= '0;
      err        <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      ack0  <= grant && !grant_id;
      ack1  <= grant &&  grant_id;
      done0 <= (state == RESP) && !owner;
      done1 <= (state == RESP) &&  owner;
      if (grant) begin
        op_m       <= sel_m;
        op_e       <= sel_e;
        op_n       <= sel_n;
        owner      <= grant_id;
        last_grant <= grant_id;
        if (sel_n == '0) begin
          result <= '0;
          err    <= 1'b1;
        end else begin
          err    <= 1'b0;
        end
      end
      if (state == WAIT && exp_done) result <= exp_result;
    end
  end

  assign exp_m = op_m;
  assign exp_e = op_e;
  assign exp_n = op_n;

endmodule

// File: tb/tb_modexp_arbiter.sv
// Bench for modexp_arbiter: the bench plays both requesters and the engine,
// and a transaction-level model predicts acks, engine launches, busy and
// done pulses cycle by cycle from the arbitration and latency rules.
module tb_modexp_arbiter;
  localparam int W     = 16;
  localparam int NEVER = 32'h7fffffff;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] m0 = '0, e0 = '0, n0 = '0, m1 = '0, e1 = '0, n1 = '0;
  logic         ack0, ack1, done0, done1, err, busy, exp_go;
  logic [W-1:0] result, exp_m, exp_e, exp_n;
  logic [W-1:0] exp_result = '0;
  logic         exp_done = 1'b0;

  always #5 clk = ~clk;

  modexp_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .m0(m0), .e0(e0), .n0(n0), .m1(m1), .e1(e1), .n1(n1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .result(result), .err(err), .busy(busy),
    .exp_go(exp_go), .exp_m(exp_m), .exp_e(exp_e), .exp_n(exp_n),
    .exp_result(exp_result), .exp_done(exp_done)
  );

  typedef struct { logic [W-1:0] m, e, n; } job_t;
  typedef struct { int who; logic [W-1:0] res; logic er; } cpl_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // requester side
  job_t q0[$], q1[$];
  bit   hold0 = 0, hold1 = 0, eager = 1;

  // engine side
  bit           eng_busy = 0;
  int           eng_at = 0, eng_lo = 1, spur_pct = 0;
  logic [W-1:0] eng_val = '0;
  int           last_real_done = -100;
  int           go_count = 0;

  // model
  bit           free = 1, lg = 1, active = 0, own = 0, isz = 0;
  int           ack_at = -1, go_at = -1, done_at = NEVER;
  logic [W-1:0] xres = '0, cap_m = '0, cap_e = '0, cap_n = '0;
  bit           xerr = 0;

  // observation logs
  int   ack_log[$];
  cpl_t dlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s cyc=%0d bound expired", name, cyc);
  endtask

  function automatic logic [W-1:0] modexp(input longint unsigned m, input longint unsigned e,
                                          input longint unsigned n);
    longint unsigned r, b;
    if (n == 0) return '0;
    r = 1 % n;
    b = m % n;
    while (e != 0) begin
      if (e[0]) r = (r * b) % n;
      b = (b * b) % n;
      e = e >> 1;
    end
    return W'(r);
  endfunction

  task automatic model_reset();
    free = 1; lg = 1; active = 0; own = 0; isz = 0;
    ack_at = -1; go_at = -1; done_at = NEVER;
    eng_busy = 0; exp_done = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ack0"}, ack0, 0);   chk({tag, "_ack1"}, ack1, 0);
    chk({tag, "_done0"}, done0, 0); chk({tag, "_done1"}, done1, 0);
    chk({tag, "_go"}, exp_go, 0);   chk({tag, "_busy"}, busy, 0);
    chk({tag, "_result"}, result, 0); chk({tag, "_err"}, err, 0);
    chk({tag, "_expm"}, exp_m, 0);  chk({tag, "_expn"}, exp_n, 0);
  endtask

  // One clock cycle: compare at the falling edge, then drive inputs for the
  // coming rising edge, then advance the model with those inputs.
  task automatic cycle();
    job_t j;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      check_all_zero("in_reset");
    end else begin
      chk("ack0", ack0, (ack_at == cyc) && !own);
      chk("ack1", ack1, (ack_at == cyc) && own);
      chk("done0", done0, (done_at == cyc) && !own);
      chk("done1", done1, (done_at == cyc) && own);
      chk("exp_go", exp_go, (go_at == cyc));
      chk("busy", busy, active && cyc < done_at);
      if (done_at == cyc) begin
        chk("result", result, xres);
        chk("err", err, xerr);
      end
      if (exp_go) begin
        chk("exp_m", exp_m, cap_m);
        chk("exp_e", exp_e, cap_e);
        chk("exp_n", exp_n, cap_n);
        chk("go_gap_ok", (cyc - last_real_done) >= 3, 1);
      end
    end
    if (ack0) ack_log.push_back(0);
    if (ack1) ack_log.push_back(1);
    if (done0 || done1) dlog.push_back('{done1 ? 1 : 0, result, err});
    if (exp_go) go_count++;

    // engine
    exp_done = 1'b0;
    if (rst_n) begin
      if (eng_busy && cyc == eng_at) begin
        exp_done = 1'b1; exp_result = eng_val; eng_busy = 0; last_real_done = cyc;
      end else if (!eng_busy && $urandom_range(0, 99) < spur_pct) begin
        exp_done = 1'b1; exp_result = W'($urandom);
      end
      if (exp_go) begin
        eng_busy = 1;
        eng_at   = cyc + int'($urandom_range(eng_lo, 6));
        eng_val  = modexp(exp_m, exp_e, exp_n);
      end
    end

    // requesters
    if (req0 && ack0) begin
      void'(q0.pop_front());
      if (!(hold0 && q0.size() > 0)) req0 = 1'b0;
    end else if (!req0 && q0.size() > 0 && (eager || $urandom_range(0, 2) == 0)) req0 = 1'b1;
    if (req0) begin j = q0[0]; m0 = j.m; e0 = j.e; n0 = j.n; end
    else begin m0 = W'($urandom); e0 = W'($urandom); n0 = W'($urandom); end
    if (req1 && ack1) begin
      void'(q1.pop_front());
      if (!(hold1 && q1.size() > 0)) req1 = 1'b0;
    end else if (!req1 && q1.size() > 0 && (eager || $urandom_range(0, 2) == 0)) req1 = 1'b1;
    if (req1) begin j = q1[0]; m1 = j.m; e1 = j.e; n1 = j.n; end
    else begin m1 = W'($urandom); e1 = W'($urandom); n1 = W'($urandom); end

    // model
    if (rst_n) begin
      if (cyc == done_at) begin active = 0; free = 1; done_at = NEVER; end
      if (active && !isz && exp_done && cyc > go_at && done_at == NEVER) done_at = cyc + 2;
      if (free && (req0 || req1)) begin
        own   = (req0 && req1) ? !lg : req1;
        lg    = own;
        cap_m = own ? m1 : m0;
        cap_e = own ? e1 : e0;
        cap_n = own ? n1 : n0;
        ack_at = cyc + 1;
        active = 1;
        free   = 0;
        isz    = (cap_n == 0);
        if (isz) begin
          go_at = -1; done_at = cyc + 2; xres = '0; xerr = 1;
        end else begin
          go_at = cyc + 1; done_at = NEVER; xres = modexp(cap_m, cap_e, cap_n); xerr = 0;
        end
      end
    end
  endtask

  task automatic run_quiet(input int budget);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0 || req1 || active) && k < budget) begin
      cycle();
      k++;
    end
    if (k >= budget) fail_now("run_quiet");
    repeat (3) cycle();
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_entry");
    model_reset();
    q0.delete(); q1.delete();
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic clear_logs();
    ack_log.delete(); dlog.delete(); go_count = 0;
  endtask

  task automatic chk_cpl(input string name, input int idx, input int who,
                         input logic [W-1:0] res, input logic er);
    if (dlog.size() <= idx) begin
      fail_now({name, "_missing"});
    end else begin
      chk({name, "_who"}, dlog[idx].who, who);
      chk({name, "_res"}, dlog[idx].res, res);
      chk({name, "_err"}, dlog[idx].er, er);
    end
  endtask

  initial begin
    int k;
    job_t j;
    model_reset();
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    chk("post_reset_result", result, 0);
    chk("post_reset_err", err, 0);
    chk("post_reset_busy", busy, 0);

    // single job on requester 0
    clear_logs();
    q0.push_back('{16'd4, 16'd13, 16'd497});
    run_quiet(100);
    chk("single_dones", dlog.size(), 1);
    chk_cpl("single", 0, 0, 16'd445, 1'b0);
    chk("single_gos", go_count, 1);

    // simultaneous requests straight from reset: requester 0 wins the tie
    reset_now(); cycle(); rst_n = 1'b1;
    clear_logs();
    q0.push_back('{16'd4, 16'd13, 16'd497});
    q1.push_back('{16'd7, 16'd0, 16'd11});
    run_quiet(100);
    chk_cpl("tie_first", 0, 0, 16'd445, 1'b0);
    chk_cpl("tie_second", 1, 1, 16'd1, 1'b0);
    chk("tie_gos", go_count, 2);

    // both held high for four jobs
    clear_logs();
    hold0 = 1; hold1 = 1;
    for (int i = 0; i < 2; i++) begin
      q0.push_back('{W'($urandom), W'($urandom), W'($urandom_range(1, 65535))});
      q1.push_back('{W'($urandom), W'($urandom), W'($urandom_range(1, 65535))});
    end
    run_quiet(200);
    hold0 = 0; hold1 = 0;
    chk("rr_acks", ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++) chk("rr_order", ack_log[i], i % 2);

    // zero modulus is rejected without touching the engine
    clear_logs();
    q1.push_back('{16'd5, 16'd3, 16'd0});
    run_quiet(50);
    chk_cpl("nzero", 0, 1, 16'd0, 1'b1);
    chk("nzero_gos", go_count, 0);

    // reset while the engine is working
    clear_logs();
    eng_lo = 5;
    q0.push_back('{16'd3, 16'hffff, 16'd65521});
    k = 0;
    while (!(active && go_at >= 0 && cyc > go_at && done_at == NEVER) && k < 50) begin
      cycle(); k++;
    end
    if (k >= 50) fail_now("reach_wait");
    reset_now();
    repeat (3) cycle();
    rst_n = 1'b1;
    eng_lo = 1;
    repeat (8) cycle();
    chk("abandoned_dones", dlog.size(), 0);
    q0.push_back('{16'd2, 16'd10, 16'd1000});
    run_quiet(100);
    chk_cpl("after_reset", 0, 0, 16'd24, 1'b0);

    // spurious engine completions outside WAIT
    clear_logs();
    spur_pct = 60;
    repeat (6) cycle();
    q0.push_back('{16'd4, 16'd13, 16'd497});
    run_quiet(100);
    chk("spur_dones", dlog.size(), 1);
    chk_cpl("spur", 0, 0, 16'd445, 1'b0);

    // randomized traffic
    eager = 0;
    spur_pct = 15;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        j.m = W'($urandom); j.e = W'($urandom);
        j.n = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        if ($urandom_range(0, 1) == 0) q0.push_back(j); else q1.push_back(j);
      end
      hold0 = ($urandom_range(0, 3) == 0);
      hold1 = ($urandom_range(0, 3) == 0);
      cycle();
    end
    hold0 = 0; hold1 = 0;
    run_quiet(2000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/modexp_arbiter.md
MODEXP_ARBITER -- requirements
Module: modexp_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the operand and result width in bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0 / req1  input  1 each  level request from requester 0 / 1; held until the matching ack.
REQ-005 m0, e0, n0 / m1, e1, n1  input  WIDTH each  operands (base, exponent, modulus); stable while the matching req is high.
REQ-006 ack0 / ack1  output  1 each  one-cycle pulse: request accepted and operands captured.
REQ-007 done0 / done1  output  1 each  one-cycle pulse: result for that requester is valid.
REQ-008 result  output  WIDTH  result of the most recently completed job; held until the next completion.
REQ-009 err  output  1  qualifies done0/done1: job rejected because n==0; held with result.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 exp_go  output  1  start pulse to the shared modexp engine.
REQ-012 exp_m, exp_e, exp_n  output  WIDTH each  engine operands, driven directly from the internal operand registers.
REQ-013 exp_result  input  WIDTH  engine result.
REQ-014 exp_done  input  1  engine one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESP.
REQ-016 IDLE, no request: the block SHALL remain in IDLE.
REQ-017 IDLE, one request: the block SHALL grant that requester.
REQ-018 IDLE, both requests: the block SHALL grant the requester not recorded in last_grant (round-robin).
REQ-019 last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-020 On the grant edge the block SHALL capture the granted m/e/n into the operand registers, record the owner, update last_grant, and pulse the owner's ack for the next cycle.
REQ-021 On the grant edge, if the captured n==0, the block SHALL go to RESP with result=0 and err=1; the engine SHALL NOT be started.
REQ-022 On the grant edge, if n!=0, the block SHALL go to ISSUE with err cleared.
REQ-023 In ISSUE, exp_go SHALL be high for exactly that one cycle; the next state SHALL be WAIT.
REQ-024 exp_go SHALL be low in every other state.
REQ-025 In WAIT, on an edge with exp_done=1 the block SHALL latch exp_result into result and go to RESP.
REQ-026 In WAIT, with exp_done=0 the block SHALL stay in WAIT with no timeout.
REQ-027 In RESP, the owner's done SHALL be high for that cycle only; the next state SHALL be IDLE.
REQ-028 The minimum re-grant gap SHALL give the engine at least 2 cycles between exp_done and the next exp_go, covering the engine's DONE-to-START return.
REQ-029 exp_done while not in WAIT SHALL be ignored.
REQ-030 A request raised while busy SHALL wait until IDLE; it is not lost as long as req stays high.
REQ-031 Latency from grant edge to done: 3 + engine cycles for n!=0; 1 cycle for n==0.
REQ-032 The non-owner's ack and done SHALL stay low throughout a job.
REQ-033 ack0 and ack1 SHALL never be high in the same cycle; the same holds for done0 and done1.
REQ-034 Width rule: all data paths SHALL be WIDTH bits with no truncation or extension inside the block.

Reset
REQ-035 While rst_n=0 the block SHALL force: state=IDLE, last_grant=1, operand registers=0, result=0, err=0.
REQ-036 While rst_n=0 the block SHALL force all of ack0/1, done0/1, exp_go and busy to 0.
REQ-037 A reset in any state, including mid-WAIT, SHALL abandon the job without issuing a done.
REQ-038 The system SHALL reset the engine on the same reset event.

Verification
REQ-039 WIDTH=16; req0 with m=4, e=13, n=497 -> ack0 one cycle after the request; exp_go single pulse; done0 with result=445, err=0.
REQ-040 From reset, req0 and req1 asserted together (req0: 4^13 mod 497; req1: m=7, e=0, n=11) -> req0 served first (445); then req1 (result=1); exactly one exp_go per job.
REQ-041 req0 and req1 held high continuously for 4 jobs -> grant order 0,1,0,1; each exp_go at least 2 cycles after the preceding exp_done.
REQ-042 req1 with n=0 -> ack1, then done1 on the next cycle with result=0, err=1; exp_go never asserted.
REQ-043 rst_n pulsed low mid-WAIT -> all outputs 0 immediately; no done; after release, a new req0 (m=2, e=10, n=1000) returns 24.
REQ-044 Spurious exp_done injected in IDLE and in ISSUE -> no state change and no done pulse.
